// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage : bus_arb_pkg

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester after last_id, with wrap-around.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [ID_W-1:0]    pick,
    output logic               any_req
);

    localparam int SW = ID_W + 1;

    logic [SW-1:0]        start_s;
    logic [SW-1:0]        sum_s;
    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [ID_W-1:0]      off_s;

    assign dbl_s   = {req, req};
    assign any_req = |req;

    // Scan origin is the slot after the previous owner.
    always_comb begin
        if ({1'b0, last_id} == SW'(NUM_REQ - 1)) begin
            start_s = '0;
        end else begin
            start_s = {1'b0, last_id} + SW'(1);
        end
    end

    // Rotate so the scan origin lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot_s = '0;
        off_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_s[i] = dbl_s[i + int'(start_s)];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? ID_W'(i) : off_s;
        end
    end

    // Map the rotated offset back to an absolute requester index.
    always_comb begin
        sum_s = start_s + {1'b0, off_s};
        if (sum_s >= SW'(NUM_REQ)) begin
            pick = ID_W'(sum_s - SW'(NUM_REQ));
        end else begin
            pick = ID_W'(sum_s);
        end
    end

endmodule : rr_priority_pick

// File: rtl/bus_arb_rr_ctrl.sv
// Round-robin bus arbiter: level req/grant, hold-limit preemption, one-cycle turnaround.
module bus_arb_rr_ctrl
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       preempt
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e          state_r,   state_nxt_s;
    logic [NUM_REQ-1:0]  grant_r,   grant_nxt_s;
    logic [ID_W-1:0]     grant_id_r, id_nxt_s;
    logic [ID_W-1:0]     last_id_r, last_nxt_s;
    logic [CNT_W-1:0]    hold_cnt_r, hold_nxt_s;
    logic                preempt_r, preempt_nxt_s;
    logic                valid_r;
    logic [ID_W-1:0]     pick_s;
    logic                any_req_s;
    logic                owner_req_s;
    logic                others_s;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id_r),
        .pick    (pick_s),
        .any_req (any_req_s)
    );

    assign owner_req_s = req[grant_id_r];
    assign others_s    = |(req & ~grant_r);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = '0;
        id_nxt_s      = '0;
        preempt_nxt_s = 1'b0;
        hold_nxt_s    = hold_cnt_r;
        last_nxt_s    = last_id_r;
        case (state_r)
            IDLE, RELEASE: begin
                if (any_req_s) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                    id_nxt_s    = pick_s;
                    hold_nxt_s  = CNT_W'(1);
                end else begin
                    state_nxt_s = IDLE;
                    hold_nxt_s  = '0;
                end
            end
            GRANT: begin
                // A voluntary drop wins over the hold limit, so no preempt pulse then.
                if (!owner_req_s) begin
                    state_nxt_s = RELEASE;
                    last_nxt_s  = grant_id_r;
                    hold_nxt_s  = '0;
                end else if ((hold_cnt_r == CNT_W'(MAX_HOLD)) && others_s) begin
                    state_nxt_s   = RELEASE;
                    last_nxt_s    = grant_id_r;
                    hold_nxt_s    = '0;
                    preempt_nxt_s = 1'b1;
                end else begin
                    grant_nxt_s = grant_r;
                    id_nxt_s    = grant_id_r;
                    if (hold_cnt_r < CNT_W'(MAX_HOLD)) begin
                        hold_nxt_s = hold_cnt_r + CNT_W'(1);
                    end else begin
                        hold_nxt_s = hold_cnt_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                hold_nxt_s  = '0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            valid_r    <= 1'b0;
            preempt_r  <= 1'b0;
            hold_cnt_r <= '0;
            last_id_r  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            grant_id_r <= id_nxt_s;
            valid_r    <= |grant_nxt_s;
            preempt_r  <= preempt_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            last_id_r  <= last_nxt_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = valid_r;
    assign grant_id    = grant_id_r;
    assign preempt     = preempt_r;

endmodule : bus_arb_rr_ctrl

// File: tb/tb_bus_arb_rr_ctrl.sv
// Directed and randomized bench for bus_arb_rr_ctrl against an owner/queue-level model.
module tb_bus_arb_rr_ctrl;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         preempt;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, how long, who owned it last.
    int m_owner;
    int m_cnt;
    int m_last;
    int m_preempt;

    bus_arb_rr_ctrl #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    function automatic int m_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic m_update(input logic [N-1:0] r, input logic rst);
        int others;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = N - 1; m_preempt = 0;
        end else if (m_owner < 0) begin
            m_preempt = 0;
            m_owner   = m_pick(r);
            m_cnt     = (m_owner >= 0) ? 1 : 0;
        end else begin
            others = 0;
            for (int i = 0; i < N; i++) if (i != m_owner && r[i]) others++;
            if (!r[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_cnt = 0; m_preempt = 0;
            end else if (m_cnt >= MH && others > 0) begin
                m_last = m_owner; m_owner = -1; m_cnt = 0; m_preempt = 1;
            end else begin
                m_preempt = 0;
                m_cnt = (m_cnt < MH) ? m_cnt + 1 : MH;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] eg;
        logic [1:0]   eid;
        logic         ev;
        logic         ep;
        eg  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        eid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        ev  = (m_owner >= 0);
        ep  = (m_preempt != 0);
        total++;
        assert (grant === eg) else begin
            bad++; $error("FAIL %s grant got %b want %b", tag, grant, eg);
        end
        total++;
        assert (grant_id === eid) else begin
            bad++; $error("FAIL %s grant_id got %0d want %0d", tag, grant_id, eid);
        end
        total++;
        assert (grant_valid === ev) else begin
            bad++; $error("FAIL %s grant_valid got %b want %b", tag, grant_valid, ev);
        end
        total++;
        assert (preempt === ep) else begin
            bad++; $error("FAIL %s preempt got %b want %b", tag, preempt, ep);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input string tag);
        req = r;
        @(posedge clk);
        m_update(r, reset);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset = 1'b1;
        step(r, "reset");
        reset = 1'b0;
    endtask

    task automatic expect_grant(input logic [N-1:0] g, input logic p, input string tag);
        total++;
        assert (grant === g && preempt === p) else begin
            bad++; $error("FAIL %s grant/preempt got %b/%b want %b/%b", tag, grant, preempt, g, p);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        int           order[$];
        int           exp_order[5];
        logic         prev_v;

        reset = 1'b1;
        req   = '0;
        m_owner = -1; m_cnt = 0; m_last = N - 1; m_preempt = 0;
        step('0, "por");
        step('0, "por");
        reset = 1'b0;

        // 1: reset mid-grant, then all requesting -> requester 0 first
        step(4'b0001, "t1_grant");
        step(4'b0001, "t1_hold");
        do_reset(4'b0001);
        expect_grant(4'b0000, 1'b0, "t1_reset_drop");
        step(4'b1111, "t1_after");
        expect_grant(4'b0001, 1'b0, "t1_first");

        // 2: single requester
        do_reset('0);
        step(4'b0100, "t2_grant");
        expect_grant(4'b0100, 1'b0, "t2_id2");
        for (int i = 0; i < 4; i++) step(4'b0100, "t2_hold");
        step(4'b0000, "t2_drop");
        step(4'b0000, "t2_idle");

        // 3: round-robin fairness, each owner drops after 3 cycles
        do_reset('0);
        exp_order = '{0, 1, 2, 3, 0};
        prev_v = 1'b0;
        for (int c = 0; c < 18; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt == 3) r[m_owner] = 1'b0;
            step(r, "t3_rr");
            if (grant_valid && !prev_v) order.push_back(int'(grant_id));
            prev_v = grant_valid;
        end
        total++;
        assert (order.size() >= 5) else begin
            bad++; $error("FAIL t3_count owners got %0d want 5", order.size());
        end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            total++;
            assert (order[i] == exp_order[i]) else begin
                bad++; $error("FAIL t3_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
            end
        end

        // 4: preemption after 8 cycles under contention
        do_reset('0);
        step(4'b0001, "t4_g0");
        for (int i = 0; i < 7; i++) step(4'b0101, "t4_hold");
        expect_grant(4'b0001, 1'b0, "t4_8th");
        step(4'b0101, "t4_gap");
        expect_grant(4'b0000, 1'b1, "t4_preempt");
        step(4'b0101, "t4_g2");
        expect_grant(4'b0100, 1'b0, "t4_owner2");
        for (int i = 0; i < 2; i++) step(4'b0101, "t4_hold2");
        step(4'b0001, "t4_rel2");
        step(4'b0001, "t4_back0");
        expect_grant(4'b0001, 1'b0, "t4_reserve0");

        // 5: no contention, 20 cycles, never preempted
        do_reset('0);
        for (int i = 0; i < 20; i++) step(4'b0001, "t5_solo");
        expect_grant(4'b0001, 1'b0, "t5_end");

        // 6: drop coincides with hold limit
        do_reset('0);
        step(4'b0010, "t6_g1");
        for (int i = 0; i < 7; i++) step(4'b1010, "t6_hold");
        step(4'b1000, "t6_drop");
        expect_grant(4'b0000, 1'b0, "t6_nopreempt");
        step(4'b1000, "t6_g3");
        expect_grant(4'b1000, 1'b0, "t6_owner3");

        // Randomized traffic with sticky requests and occasional reset
        do_reset('0);
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            end
            reset = ($urandom_range(0, 149) == 0);
            step(r, "rand");
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arb_rr_ctrl

// File: doc/bus_arb_rr_ctrl.md
Name: bus_arb_rr_ctrl

Overview:
Round-robin bus arbiter controller that shares one bus between NUM_REQ requesters. It uses a level req/grant handshake. A grant is held while the owner keeps req high, with forced preemption after MAX_HOLD cycles if other requesters are waiting. There is a mandatory one-cycle bus turnaround between owners. It sits between the requester masters and the shared bus mux; grant_id drives the mux select.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
MAX_HOLD, 8, max consecutive grant cycles before preemption when another req is pending (>= 2)
ID_W, $clog2(NUM_REQ), localparam, width of grant_id
CNT_W, $clog2(MAX_HOLD+1), localparam, hold counter width

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  level request per requester, held until done
grant  output  NUM_REQ  registered one-hot grant, all-zero when bus free
grant_valid  output  1  registered, equals |grant
grant_id  output  ID_W  registered index of current owner; 0 when no grant
preempt  output  1  registered one-cycle pulse when the owner is forcibly revoked

Behaviour:
- Reset (sampled at posedge): grant=0, grant_valid=0, grant_id=0, preempt=0, state=IDLE, hold_cnt=0, last_id=NUM_REQ-1 (so requester 0 has highest priority first). Reset mid-grant drops the grant at the next edge, with no RELEASE cycle.
- All outputs are registered. No combinational path from req to grant.
- Arbitration (IDLE and RELEASE): pick the first i with req[i]=1, scanning from (last_id+1) mod NUM_REQ upward with wrap-around.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any req: grant[pick]=1 at the next edge, grant_id=pick, hold_cnt=1, go to GRANT.
  - Latency: req high in cycle n means grant is visible in cycle n+1.
  - Otherwise stay in IDLE.
- GRANT:
  - If req[grant_id]=0: go to RELEASE; grant=0 next cycle; last_id=grant_id.
  - Else if hold_cnt==MAX_HOLD and any other req is high: go to RELEASE, grant=0, last_id=grant_id, preempt=1 for that single cycle.
  - Else hold the grant; hold_cnt increments and saturates at MAX_HOLD.
  - Counter rule: the grant is visible for at most MAX_HOLD cycles under contention.
- RELEASE:
  - grant=0 and preempt=0 (after its pulse) in this cycle.
  - Arbitrate as in IDLE, excluding no one. The preempted owner may re-win only if it is the sole requester.
  - Any req: go to GRANT next edge. None: go to IDLE.
  - Gap between owners is exactly 1 zero-grant cycle.
- Simultaneous events:
  - Owner drops req in the same cycle the limit is hit: treated as normal release, preempt stays 0.
  - New req arriving during GRANT is ignored until RELEASE.
- A requester dropping req while not granted is simply withdrawn; no state is kept.
- A preempted requester keeps req high and is re-served by round-robin order.

Decomposition:
- Shared package bus_arb_pkg: state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2), default NUM_REQ/MAX_HOLD constants.
- One natural sub-module: rr_priority_pick. It is combinational: inputs req, last_id; outputs pick index and any_req; implemented as a double-width rotate and priority encode.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
1. Reset mid-grant: req=4'b0001 granted, assert reset 1 cycle -> grant=0, grant_id=0, grant_valid=0 next edge; after deassert with req=4'b1111 -> grant=4'b0001.
2. Single requester: req=4'b0100 at cycle n -> grant=4'b0100, grant_id=2 at n+1, held; drop req at m -> grant=0 at m+1, then IDLE.
3. Round-robin fairness: req=4'b1111, each owner drops req after 3 grant cycles and re-raises it -> owner order 0,1,2,3,0, with exactly one zero-grant cycle between owners.
4. Preemption: req0 held continuously, req2 raised -> grant0 for 8 cycles, preempt=1 in the following (gap) cycle, grant=4'b0100 the cycle after; req0 is served again after req2 releases.
5. No contention: req0 alone held 20 cycles -> grant=4'b0001 throughout, preempt never asserts, hold_cnt saturates at 8.
6. Simultaneous drop and limit: owner 1 drops req on the cycle hold_cnt==8 while req3 is pending -> RELEASE with preempt=0, then grant=4'b1000.
